// File: rtl/if_fetch_queue.sv
// ----------------------------------------------------------------------------
// if_fetch_queue
//
// Instruction fetch queue between the PC/IM fetch stage and decode of the
// pipelined MIPS core. Fetched {pc, instr} pairs are captured in a small
// circular FIFO and the oldest entry is offered to decode through a
// valid/ready handshake. in_ready depends only on occupancy, so there is no
// combinational path from decode back into fetch. pc_stop holds the PC while
// the queue is full. A redirect (flush) drops every queued entry.
//
// Optional build macro: IFQ_ADEL_CHECK_EN
//   When defined, each entry also carries a 5-bit exception code. Pushes of a
//   misaligned or out-of-range PC are tagged AdEL (5'd4) and their instruction
//   is replaced by a nop (32'h0). The code is presented on out_exc.
// ----------------------------------------------------------------------------
module if_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter int          PTR_W    = 2,
    parameter logic [31:0] PC_BASE  = 32'h00003000,
    parameter logic [31:0] PC_LIMIT = 32'h00006FFC
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [31:0]      in_pc,
    input  logic [31:0]      in_instr,
    output logic             in_ready,
    output logic             pc_stop,
    output logic             out_valid,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_instr,
    input  logic             out_ready,
    input  logic             flush,
    output logic [PTR_W:0]   count
`ifdef IFQ_ADEL_CHECK_EN
    ,
    output logic [4:0]       out_exc
`endif
);

    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [4:0]       EXC_ADEL = 5'd4;
    localparam logic [4:0]       EXC_NONE = 5'd0;

    // Reject configurations the pointer arithmetic cannot support: the
    // pointers wrap naturally only when DEPTH is exactly 2**PTR_W.
    generate
        if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) ||
            ((1 << PTR_W) != DEPTH) || (PC_BASE > PC_LIMIT)) begin : g_bad_cfg
            $error("if_fetch_queue: inconsistent DEPTH/PTR_W/PC range parameters");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Storage and control state
    // ------------------------------------------------------------------
    logic [31:0]      pc_mem    [DEPTH];
    logic [31:0]      instr_mem [DEPTH];

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   cnt;

    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    // Value actually written into the instruction slot on a push.
    logic [31:0]      wr_instr;

`ifdef IFQ_ADEL_CHECK_EN
    logic [4:0]       exc_mem [DEPTH];
    logic [4:0]       wr_exc;

    // Classify the incoming PC: misaligned or outside the legal text window
    // raises AdEL and the fetched word is replaced by a nop.
    always_comb begin
        wr_exc   = EXC_NONE;
        wr_instr = in_instr;
        if ((in_pc[1:0] != 2'b00) || (in_pc < PC_BASE) || (in_pc > PC_LIMIT)) begin
            wr_exc   = EXC_ADEL;
            wr_instr = 32'h0;
        end
    end
`else
    assign wr_instr = in_instr;
`endif

    // ------------------------------------------------------------------
    // Flags and handshake
    // ------------------------------------------------------------------
    assign full      = (cnt == CNT_FULL);
    assign empty     = (cnt == '0);

    assign in_ready  = ~full;
    assign pc_stop   = full;
    assign out_valid = ~empty;

    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    assign count     = cnt;

    // Pointer and occupancy update; reset outranks flush, flush outranks any
    // same-cycle push or pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CNT_ONE;
                2'b01:   cnt <= cnt - CNT_ONE;
                default: cnt <= cnt;
            endcase
        end
    end

    // Entry payload write; contents are meaningful only between rd_ptr and
    // wr_ptr, so the payload needs no reset and may be written during flush.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= in_pc;
            instr_mem[wr_ptr] <= wr_instr;
`ifdef IFQ_ADEL_CHECK_EN
            exc_mem[wr_ptr]   <= wr_exc;
`endif
        end
    end

    // Head entry to decode; an empty queue reads as a nop at address zero.
    always_comb begin
        out_pc    = 32'h0;
        out_instr = 32'h0;
`ifdef IFQ_ADEL_CHECK_EN
        out_exc   = EXC_NONE;
`endif
        if (!empty) begin
            out_pc    = pc_mem[rd_ptr];
            out_instr = instr_mem[rd_ptr];
`ifdef IFQ_ADEL_CHECK_EN
            out_exc   = exc_mem[rd_ptr];
`endif
        end
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
// ----------------------------------------------------------------------------
// tb_if_fetch_queue
//
// Directed scenarios followed by a randomized run, all checked against a
// queue-based reference model of the fetch FIFO. Build with
// IFQ_ADEL_CHECK_EN defined to also exercise the AdEL tagging.
// ----------------------------------------------------------------------------
module tb_if_fetch_queue;

    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_pc = 32'h0;
    logic [31:0] in_instr = 32'h0;
    logic        in_ready;
    logic        pc_stop;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_ready = 1'b0;
    logic        flush = 1'b0;
    logic [PTR_W:0] count;
`ifdef IFQ_ADEL_CHECK_EN
    logic [4:0]  out_exc;
`endif

    always #5 clk = ~clk;

    if_fetch_queue #(
        .DEPTH   (DEPTH),
        .PTR_W   (PTR_W),
        .PC_BASE (32'h00003000),
        .PC_LIMIT(32'h00006FFC)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_pc    (in_pc),
        .in_instr (in_instr),
        .in_ready (in_ready),
        .pc_stop  (pc_stop),
        .out_valid(out_valid),
        .out_pc   (out_pc),
        .out_instr(out_instr),
        .out_ready(out_ready),
        .flush    (flush),
        .count    (count)
`ifdef IFQ_ADEL_CHECK_EN
        ,
        .out_exc  (out_exc)
`endif
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  exc;
    } ent_t;

    ent_t q[$];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Entry as decode should see it, derived from the fetch address rules.
    function automatic ent_t mk(input logic [31:0] pc, input logic [31:0] ins);
        ent_t e;
        e.pc    = pc;
        e.instr = ins;
        e.exc   = 5'd0;
`ifdef IFQ_ADEL_CHECK_EN
        if ((pc % 4 != 0) || (pc < 32'h3000) || (pc > 32'h6FFC)) begin
            e.exc   = 5'd4;
            e.instr = 32'h0;
        end
`endif
        return e;
    endfunction

    task automatic check_model(input string tag);
        int n;
        n = q.size();
        chk({tag, ".count"},     32'(count),     32'(n));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(n != 0));
        chk({tag, ".in_ready"},  32'(in_ready),  32'(n < DEPTH));
        chk({tag, ".pc_stop"},   32'(pc_stop),   32'(n == DEPTH));
        chk({tag, ".out_pc"},    out_pc,    (n != 0) ? q[0].pc    : 32'h0);
        chk({tag, ".out_instr"}, out_instr, (n != 0) ? q[0].instr : 32'h0);
`ifdef IFQ_ADEL_CHECK_EN
        chk({tag, ".out_exc"},   32'(out_exc),   (n != 0) ? 32'(q[0].exc) : 32'h0);
`endif
    endtask

    // One clock: drive at the falling edge, model the rising edge, check at
    // the next falling edge.
    task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                        input logic rdy, input logic fl, input logic rst, input string tag);
        bit full_b;
        bit do_pop;
        in_valid  = v;
        in_pc     = pc;
        in_instr  = ins;
        out_ready = rdy;
        flush     = fl;
        reset     = rst;
        @(posedge clk);
        if (rst || fl) begin
            q.delete();
        end else begin
            full_b = (q.size() == DEPTH);
            do_pop = (q.size() > 0) && rdy;
            if (do_pop) void'(q.pop_front());
            if (v && !full_b) q.push_back(mk(pc, ins));
        end
        @(negedge clk);
        check_model(tag);
    endtask

    initial begin
        @(negedge clk);

        // Reset state
        step(1'b1, 32'h3000, 32'h1111_1111, 1'b1, 1'b0, 1'b1, "rst");
        chk("rst.out_valid", 32'(out_valid), 32'h0);
        chk("rst.out_pc",    out_pc,         32'h0);
        chk("rst.out_instr", out_instr,      32'h0);
        chk("rst.in_ready",  32'(in_ready),  32'h1);
        chk("rst.pc_stop",   32'(pc_stop),   32'h0);
        chk("rst.count",     32'(count),     32'h0);

        // Single push becomes visible after the edge
        step(1'b1, 32'h3000, 32'h2401_0001, 1'b0, 1'b0, 1'b0, "push1");
        chk("push1.out_valid", 32'(out_valid), 32'h1);
        chk("push1.out_pc",    out_pc,         32'h3000);
        chk("push1.out_instr", out_instr,      32'h2401_0001);
        chk("push1.count",     32'(count),     32'h1);

        // Fill to full, fifth push dropped, drain in order
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, "rst2");
        for (int i = 0; i < 4; i++)
            step(1'b1, 32'h3000 + 32'(4 * i), 32'hA000_0000 + 32'(i), 1'b0, 1'b0, 1'b0, "fill");
        chk("full.count",    32'(count),    32'h4);
        chk("full.in_ready", 32'(in_ready), 32'h0);
        chk("full.pc_stop",  32'(pc_stop),  32'h1);
        step(1'b1, 32'h3010, 32'hA000_0004, 1'b0, 1'b0, 1'b0, "push5");
        chk("push5.count", 32'(count), 32'h4);
        for (int i = 0; i < 4; i++) begin
            chk("drain.out_pc", out_pc, 32'h3000 + 32'(4 * i));
            step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, "drain");
        end
        chk("drain.count", 32'(count), 32'h0);

        // Streaming push+pop across pointer wrap
        step(1'b1, 32'h3000, 32'hB000_0000, 1'b0, 1'b0, 1'b0, "stream0");
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 32'h3004 + 32'(4 * i), 32'hB000_0001 + 32'(i), 1'b1, 1'b0, 1'b0, "stream");
            chk("stream.count",  32'(count), 32'h1);
            chk("stream.out_pc", out_pc,     32'h3004 + 32'(4 * i));
        end

        // Flush with simultaneous push and pop
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, "rst3");
        for (int i = 0; i < 3; i++)
            step(1'b1, 32'h3100 + 32'(4 * i), 32'hC000_0000 + 32'(i), 1'b0, 1'b0, 1'b0, "fill3");
        step(1'b1, 32'h4000, 32'hC000_00FF, 1'b1, 1'b1, 1'b0, "flush");
        chk("flush.count",     32'(count),     32'h0);
        chk("flush.out_valid", 32'(out_valid), 32'h0);
        chk("flush.out_pc",    out_pc,         32'h0);
        chk("flush.in_ready",  32'(in_ready),  32'h1);

        // Reset mid-operation
        for (int i = 0; i < 3; i++)
            step(1'b1, 32'h3200 + 32'(4 * i), 32'hD000_0000 + 32'(i), 1'b0, 1'b0, 1'b0, "fill3b");
        chk("pre_rst.count", 32'(count), 32'h3);
        step(1'b1, 32'h5000, 32'hD000_00FF, 1'b0, 1'b1, 1'b1, "midrst");
        chk("midrst.count",     32'(count),     32'h0);
        chk("midrst.out_valid", 32'(out_valid), 32'h0);
        chk("midrst.pc_stop",   32'(pc_stop),   32'h0);

`ifdef IFQ_ADEL_CHECK_EN
        // Address error tagging
        step(1'b1, 32'h3002, 32'hE000_0001, 1'b0, 1'b0, 1'b0, "adel0");
        step(1'b1, 32'h2FFC, 32'hE000_0002, 1'b0, 1'b0, 1'b0, "adel1");
        step(1'b1, 32'h3004, 32'hE000_0003, 1'b0, 1'b0, 1'b0, "adel2");
        chk("adel0.out_exc",   32'(out_exc), 32'h4);
        chk("adel0.out_instr", out_instr,    32'h0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, "adel_pop0");
        chk("adel1.out_exc",   32'(out_exc), 32'h4);
        chk("adel1.out_instr", out_instr,    32'h0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, "adel_pop1");
        chk("adel2.out_exc",   32'(out_exc), 32'h0);
        chk("adel2.out_instr", out_instr,    32'hE000_0003);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, "adel_rst");
`endif

        // Randomized traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            logic [31:0] pc;
            logic        v;
            logic        rdy;
            logic        fl;
            logic        rst;
            v   = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 2) != 0);
            fl  = ($urandom_range(0, 24) == 0);
            rst = ($urandom_range(0, 59) == 0);
            pc  = 32'h3000 + 32'(4 * $urandom_range(0, 4095));
            if ($urandom_range(0, 9) == 0) pc = $urandom();
            step(v, pc, $urandom(), rdy, fl, rst, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
- Instruction fetch queue between the PC/IM fetch stage and the decode stage of the pipelined MIPS core.
- Each cycle it captures the fetched {PC, instruction} pair into a small circular FIFO and presents the oldest entry to decode through a valid/ready handshake.
- Decode and hazard stalls are decoupled from fetch. The `pc_stop` output drives the PC register's stop input.
- A branch/jump redirect flushes all queued entries.

Parameters:
- DEPTH, 4, number of queue entries; power of two, minimum 2.
- PTR_W, 2, pointer width; equals log2(DEPTH).
- PC_BASE, 32'h00003000, lowest legal instruction address.
- PC_LIMIT, 32'h00006FFC, highest legal instruction address.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  fetch stage presents a valid {in_pc, in_instr} pair.
- in_pc  input  32  address of the fetched instruction.
- in_instr  input  32  fetched instruction word.
- in_ready  output  1  queue can accept a push this cycle.
- pc_stop  output  1  equals ~in_ready; drives the PC stop input.
- out_valid  output  1  head entry is valid.
- out_pc  output  32  PC of the head entry.
- out_instr  output  32  instruction of the head entry.
- out_ready  input  1  decode consumes the head entry this cycle.
- flush  input  1  redirect: discard all entries.
- count  output  PTR_W+1  number of occupied entries, 0..DEPTH.

Behaviour:
- Storage and state:
  - Circular buffer of DEPTH entries, each holding {pc[31:0], instr[31:0]}.
  - Read pointer rd_ptr, write pointer wr_ptr (PTR_W bits each, wrap modulo DEPTH), occupancy counter cnt (PTR_W+1 bits).
- Flags (combinational from cnt): full = (cnt == DEPTH), empty = (cnt == 0).
- Handshake signals:
  - in_ready = ~full. It does not depend on out_ready, so no combinational path exists from decode to fetch.
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
- Outputs:
  - out_valid = ~empty.
  - out_pc and out_instr are the head entry when non-empty, and 32'h0 when empty (the instruction reads as a nop).
- Latency: an entry pushed at edge N is visible on the outputs after edge N (cnt 0 → 1). There is no same-cycle bypass.
- Push only: write entry at wr_ptr, wr_ptr += 1, cnt += 1.
- Pop only: rd_ptr += 1, cnt -= 1.
- Push and pop in the same cycle (not full, not empty): write and advance both pointers; cnt unchanged.
- Full: push is blocked, and pc_stop = 1 holds the PC. A pop while full frees the slot, but in_ready only rises on the following cycle.
- Empty: out_ready is ignored; no pop occurs and rd_ptr is unchanged.
- Flush:
  - Highest priority. On the edge it sets rd_ptr = wr_ptr = 0 and cnt = 0.
  - Any same-cycle push or pop is discarded.
  - Queue storage contents are don't-care afterwards.
- Reset:
  - Identical to flush and has priority over everything, including flush.
  - After reset: out_valid = 0, out_pc = 0, out_instr = 0, in_ready = 1, pc_stop = 0, count = 0.
- Wrap-around: pointers roll over from DEPTH-1 to 0 with no gaps or duplicated entries.
- Ordering: strict FIFO; entries are never reordered.

Optional Feature:
- Macro IFQ_ADEL_CHECK_EN, when defined:
  - Adds output port out_exc (5 bits) and stores an exception code per entry.
  - At push: exc = 5'd4 (AdEL) if in_pc[1:0] != 0, or in_pc < PC_BASE, or in_pc > PC_LIMIT; otherwise exc = 5'd0.
  - When exc = 4, the stored instr is forced to 32'h0.
  - out_exc is 0 when the queue is empty and resets to 0.
- When undefined: no out_exc port, no comparator logic, and instr is stored unmodified.

Test Plan:
- Reset, then push pc=0x3000/instr=0x24010001 with out_ready=0 → next cycle out_valid=1, out_pc=0x3000, out_instr=0x24010001, count=1.
- Push 4 entries (pc 0x3000..0x300C) with out_ready=0 → count=4, in_ready=0, pc_stop=1. A fifth push is dropped, and subsequent pops return 0x3000, 0x3004, 0x3008, 0x300C in order.
- Continuous push and pop for 10 cycles from count=1 → count stays 1 and out_pc advances by 4 each cycle across pointer wrap, with no gaps.
- Fill to 3 entries, then assert flush together with in_valid and out_ready → next cycle count=0, out_valid=0, out_pc=0, in_ready=1.
- Assert reset mid-operation with count=3 and in_valid=1 → next cycle count=0, out_valid=0, pc_stop=0.
- IFQ_ADEL_CHECK_EN defined: push pc=0x3002, then pc=0x2FFC, then pc=0x3004 → out_exc reads 4, 4, 0; out_instr reads 0 for the first two entries and passes through unmodified for the third.
